// File: rtl/oled_seq_engine.sv
// Table-driven OLED sequencer: fetches 12-bit ops (SEND/PIN/DELAY/END) from an external ROM and drives the PmodOLED pins.
// Optional build macro OLED_SEQ_REPEAT_EN: SEND arg[9] resends the byte (count in the following ROM word).
module oled_seq_engine #(
  parameter int ADDR_W      = 6,
  parameter int CLK_DIV     = 4,
  parameter int CLKS_PER_MS = 100000,
  parameter int DLY_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              cs,
  output logic              sclk,
  output logic              sdo,
  output logic              dc,
  output logic              res,
  output logic              vdd,
  output logic              vbat,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_SPI_LOAD  = 4'd3;
  localparam logic [3:0] S_SPI_SHIFT = 4'd4;
  localparam logic [3:0] S_SPI_GAP   = 4'd5;
  localparam logic [3:0] S_PIN       = 4'd6;
  localparam logic [3:0] S_DELAY     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int PRE_W = $clog2(CLKS_PER_MS + 1);

  logic [3:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              en_q;
  logic [7:0]        tx_byte;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [DLY_W-1:0]  ms_cnt;
  logic              run_state;
  logic              div_end;
  logic              pre_end;
`ifdef OLED_SEQ_REPEAT_EN
  logic              rep_load;
  logic [7:0]        rep_cnt;
`endif

  assign run_state = (state != S_IDLE) && (state != S_DONE);
  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign pre_end   = (pre_cnt == PRE_W'(CLKS_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      rom_addr <= '0;
      en_q     <= 1'b0;
      cs       <= 1'b1;
      sclk     <= 1'b1;
      sdo      <= 1'b0;
      dc       <= 1'b0;
      res      <= 1'b0;
      vdd      <= 1'b1;
      vbat     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_byte  <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      pre_cnt  <= '0;
      ms_cnt   <= '0;
`ifdef OLED_SEQ_REPEAT_EN
      rep_load <= 1'b0;
      rep_cnt  <= '0;
`endif
    end else begin
      en_q <= en;
      // Abort has priority over whatever the current state would do, including END.
      if (run_state && !en) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        cs    <= 1'b1;
        sclk  <= 1'b1;
`ifdef OLED_SEQ_REPEAT_EN
        rep_load <= 1'b0;
        rep_cnt  <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (en && !en_q) begin
              pc    <= base_addr;
              busy  <= 1'b1;
              state <= S_FETCH;
            end
          end
          S_FETCH: begin
            rom_addr <= pc;
            state    <= S_DECODE;
          end
          S_DECODE: begin
            pc <= pc + 1'b1;
            case (rom_data[11:10])
              2'b00: begin
                cs      <= 1'b0;
                dc      <= rom_data[8];
                sdo     <= rom_data[7];
                tx_byte <= rom_data[7:0];
                state   <= S_SPI_LOAD;
`ifdef OLED_SEQ_REPEAT_EN
                // Point the ROM at the count word so it can be latched during SPI_LOAD.
                if (rom_data[9]) begin
                  pc       <= pc + ADDR_W'(2);
                  rom_addr <= pc + 1'b1;
                  rep_load <= 1'b1;
                end
`endif
              end
              2'b01: begin
                res   <= rom_data[0];
                vdd   <= rom_data[1];
                vbat  <= rom_data[2];
                state <= S_PIN;
              end
              2'b10: begin
                ms_cnt  <= DLY_W'(rom_data[9:0]);
                pre_cnt <= '0;
                state   <= S_DELAY;
              end
              default: begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
          S_SPI_LOAD: begin
            sclk    <= 1'b0;
            shreg   <= tx_byte;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= S_SPI_SHIFT;
`ifdef OLED_SEQ_REPEAT_EN
            if (rep_load) begin
              rep_cnt  <= rom_data[7:0];
              rep_load <= 1'b0;
            end
`endif
          end
          S_SPI_SHIFT: begin
            if (div_end) begin
              div_cnt <= '0;
              if (!sclk) begin
                sclk <= 1'b1;
              end else if (bit_cnt == 3'd7) begin
                cs    <= 1'b1;
                state <= S_SPI_GAP;
              end else begin
                sclk    <= 1'b0;
                sdo     <= shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          S_SPI_GAP: begin
            if (div_end) begin
              div_cnt <= '0;
              state   <= S_FETCH;
`ifdef OLED_SEQ_REPEAT_EN
              if (rep_cnt != 8'd0) begin
                rep_cnt <= rep_cnt - 8'd1;
                cs      <= 1'b0;
                sdo     <= tx_byte[7];
                state   <= S_SPI_LOAD;
              end
`endif
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          S_PIN: state <= S_FETCH;
          S_DELAY: begin
            // arg ms takes exactly arg*CLKS_PER_MS cycles; arg=0 still spends this one cycle.
            if ((ms_cnt == '0) || ((ms_cnt == DLY_W'(1)) && pre_end)) begin
              state <= S_FETCH;
            end else if (pre_end) begin
              pre_cnt <= '0;
              ms_cnt  <= ms_cnt - 1'b1;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (!en) begin
              done  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_seq_engine.sv
// Scoreboarded bench for oled_seq_engine: SPI bytes checked against a queue, timing measured in cycles.
module tb_oled_seq_engine;

  localparam int AW  = 6;
  localparam int DIV = 2;
  localparam int MS  = 10;
  localparam int SEND_CYC = 2 + 1 + 16*DIV + DIV;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [AW-1:0] base_addr, rom_addr;
  logic [11:0]   rom_data;
  logic          cs, sclk, sdo, dc, res, vdd, vbat, busy, done;

  logic [11:0]   rom [0:(1<<AW)-1];
  logic [8:0]    exp_q [$];
  int            res_t [$];
  int            addr_log [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            nb = 0;
  logic [7:0]    sh = 8'h00;
  logic          sclk_q = 1'b1;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  oled_seq_engine #(.ADDR_W(AW), .CLK_DIV(DIV), .CLKS_PER_MS(MS), .DLY_W(10)) dut (
    .clk(clk), .rst(rst), .en(en), .base_addr(base_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .cs(cs), .sclk(sclk), .sdo(sdo), .dc(dc), .res(res),
    .vdd(vdd), .vbat(vbat), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] op_send(input logic rep, input logic d, input logic [7:0] b);
    return {2'b00, rep, d, b};
  endfunction
  function automatic logic [11:0] op_pin(input logic [2:0] p);
    return {2'b01, 7'd0, p};
  endfunction
  function automatic logic [11:0] op_dly(input logic [9:0] m);
    return {2'b10, m};
  endfunction
  localparam logic [11:0] OP_END = 12'hC00;

  // SPI monitor: shift sdo on each sclk rise while cs is low; partial bytes are dropped on cs high.
  always @(negedge clk) begin
    if (rst || cs) begin
      nb = 0;
    end else if (sclk && !sclk_q) begin
      sh = {sh[6:0], sdo};
      nb++;
      if (nb == 8) begin
        if (exp_q.size() == 0) check("sb_unexpected_byte", {23'd0, dc, sh}, 32'h1FF);
        else check("sb_byte", {23'd0, dc, sh}, {23'd0, exp_q.pop_front()});
        nb = 0;
      end
    end
    sclk_q = sclk;
  end

  task automatic run(input logic [AW-1:0] b, output int b2d, output int csl);
    int k_busy, k_done;
    logic prev_res;
    int prev_addr;
    k_busy = -1; k_done = -1; csl = 0;
    res_t.delete(); addr_log.delete();
    prev_res = res; prev_addr = rom_addr;
    base_addr = b;
    en = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (busy && k_busy < 0) k_busy = n;
      if (!cs) csl++;
      if (res !== prev_res) res_t.push_back(n);
      prev_res = res;
      if (int'(rom_addr) != prev_addr) addr_log.push_back(int'(rom_addr));
      prev_addr = int'(rom_addr);
      if (done) begin k_done = n; break; end
    end
    check("seq_timeout", done, 1'b1);
    check("end_busy", busy, 1'b0);
    b2d = k_done - k_busy;
    repeat (3) begin
      @(negedge clk);
      check("done_hold", {busy, done}, 2'b01);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("done_clear", done, 1'b0);
  endtask

  initial begin
    int b2d, csl, nbytes;
    for (int i = 0; i < (1<<AW); i++) rom[i] = OP_END;
    rom[0]  = op_send(1'b0, 1'b0, 8'hAE);
    rom[1]  = OP_END;
    rom[2]  = op_pin(3'b001);
    rom[3]  = op_dly(10'd3);
    rom[4]  = op_pin(3'b000);
    rom[5]  = op_pin(3'b001);
    rom[6]  = op_dly(10'd0);
    rom[7]  = op_pin(3'b000);
    rom[8]  = OP_END;
    rom[10] = op_pin(3'b011);
    rom[11] = op_send(1'b0, 1'b1, 8'h55);
    rom[12] = OP_END;
    rom[20] = op_send(1'b1, 1'b1, 8'h00);
    rom[21] = 12'h003;
    rom[22] = OP_END;
    rom[23] = OP_END;
    rom[63] = op_pin(3'b001);

    rst = 1'b1; en = 1'b0; base_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("reset_pins", {cs, sclk, sdo, dc, res, vdd, vbat, busy, done}, 9'b110001100);
      check("reset_rom_addr", rom_addr, 0);
    end

    // Single command byte 0xAE.
    exp_q.push_back({1'b0, 8'hAE});
    run(0, b2d, csl);
    check("send_latency", b2d, SEND_CYC + 2);
    check("send_cs_low", csl, 1 + 16*DIV);

    // PIN / DELAY timing.
    run(2, b2d, csl);
    check("pin_edges", res_t.size(), 4);
    if (res_t.size() == 4) begin
      check("delay3_span", res_t[1] - res_t[0], 1 + 2 + 3*MS + 2);
      check("delay0_span", res_t[3] - res_t[2], 1 + 2 + 1 + 2);
    end
    check("pin_vdd_vbat", {vdd, vbat}, 2'b00);

    // Abort after three bits, then restart from the same base.
    base_addr = 6'd10;
    en = 1'b1;
    for (int i = 0; i < 300 && nb != 3; i++) @(negedge clk);
    check("abort_reached_bit3", nb, 3);
    en = 1'b0;
    @(negedge clk);
    check("abort_state", {cs, sclk, busy}, 3'b110);
    check("abort_pins_kept", {res, vdd, vbat}, 3'b110);
    repeat (3) @(negedge clk);
    exp_q.push_back({1'b1, 8'h55});
    run(10, b2d, csl);
    check("restart_latency", b2d, 1 + 2 + SEND_CYC + 2);

    // Address wrap from the top of the table.
    exp_q.push_back({1'b0, 8'hAE});
    run(6'd63, b2d, csl);
    check("wrap_log_len_ok", addr_log.size() >= 2, 1'b1);
    if (addr_log.size() >= 2) begin
      check("wrap_first_fetch", addr_log[0], 63);
      check("wrap_second_fetch", addr_log[1], 0);
    end

    // Repeat-flagged SEND.
`ifdef OLED_SEQ_REPEAT_EN
    nbytes = 4;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h00});
    run(20, b2d, csl);
    check("repeat_latency", b2d, 2 + 4*(1 + 17*DIV) + 2);
`else
    nbytes = 2;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h03});
    run(20, b2d, csl);
    check("repeat_latency", b2d, 2*SEND_CYC + 2);
`endif
    check("repeat_cs_low", csl, nbytes*(1 + 16*DIV));

    // Reset in the middle of a byte.
    base_addr = '0;
    en = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pins", {cs, sclk, sdo, dc, res, vdd, vbat, busy, done}, 9'b110001100);
    check("midrst_rom_addr", rom_addr, 0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
